// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus for sync_fifo_param: write/read requests, data, threshold and status.
// master drives requests and control; slave is the FIFO.
interface sync_fifo_param_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [AW:0]   thresh_level;
    logic          flag_clr;
    logic [DW-1:0] dout;
    logic [AW:0]   fcount;
    logic          ffull;
    logic          fempty;
    logic          fthreshold;
    logic          foverflow;
    logic          funderflow;

    modport master (
        output wr, rd, din, thresh_level, flag_clr,
        input  dout, fcount, ffull, fempty, fthreshold, foverflow, funderflow
    );

    modport slave (
        input  wr, rd, din, thresh_level, flag_clr,
        output dout, fcount, ffull, fempty, fthreshold, foverflow, funderflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO, DW x DEPTH; dout one cycle after rd (FWFT=0) or head shown continuously (FWFT=1).
// Writes when full / reads when empty are dropped and latched into sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    parameter int FWFT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_param_if.slave  bus
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr, rptr, wptr_n, rptr_n;
    logic [AW:0]   count_q;
    logic          full_q, empty_q;
    logic          ovf_q, unf_q;
    logic          wr_acc, rd_acc;

    assign wr_acc = bus.wr && !full_q;
    assign rd_acc = bus.rd && !empty_q;
    assign wptr_n = wptr + (AW+1)'(wr_acc);
    assign rptr_n = rptr + (AW+1)'(rd_acc);

    // Status is derived from next-state pointers so it is correct the cycle after the operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr    <= wptr_n;
            rptr    <= rptr_n;
            count_q <= wptr_n - rptr_n;
            full_q  <= (wptr_n[AW-1:0] == rptr_n[AW-1:0]) && (wptr_n[AW] != rptr_n[AW]);
            empty_q <= (wptr_n == rptr_n);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[AW-1:0]] <= bus.din;
        end
    end

    // A new error event beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.wr && full_q) begin
                ovf_q <= 1'b1;
            end else if (bus.flag_clr) begin
                ovf_q <= 1'b0;
            end
            if (bus.rd && empty_q) begin
                unf_q <= 1'b1;
            end else if (bus.flag_clr) begin
                unf_q <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.dout = empty_q ? '0 : mem[rptr[AW-1:0]];
        end else begin : g_std
            logic [DW-1:0] dout_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rptr[AW-1:0]];
                end
            end
            assign bus.dout = dout_q;
        end
    endgenerate

    assign bus.fcount     = count_q;
    assign bus.ffull      = full_q;
    assign bus.fempty     = empty_q;
    assign bus.foverflow  = ovf_q;
    assign bus.funderflow = unf_q;
    // Threshold above DEPTH can never be reached since count_q tops out at DEPTH.
    assign bus.fthreshold = (count_q >= bus.thresh_level);
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. Successor to the fixed 8-bit x 16 FIFO. Adds:
- Configurable width and depth.
- A run-time programmable threshold level.
- An occupancy count output.
- Sticky overflow/underflow error flags with software clear.
- Selectable standard or first-word-fall-through (FWFT) read mode.

It sits between a producer and a consumer in the same clock domain.

Parameters:
- DW, 8: data width in bits.
- DEPTH, 16: number of entries; must be a power of 2, minimum 4.
- AW, log2(DEPTH): address width. Derived; not overridden by the instantiator.
- FWFT, 0: read mode. 0 = standard (registered read); 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr  in  1  write request.
- rd  in  1  read request.
- din  in  DW  write data.
- thresh_level  in  AW+1  programmable threshold level, 0..DEPTH.
- flag_clr  in  1  synchronous clear of sticky foverflow/funderflow.
- dout  out  DW  read data.
- fcount  out  AW+1  current occupancy, 0..DEPTH.
- ffull  out  1  FIFO holds DEPTH entries.
- fempty  out  1  FIFO holds 0 entries.
- fthreshold  out  1  fcount >= thresh_level.
- foverflow  out  1  sticky: a write was attempted while full.
- funderflow  out  1  sticky: a read was attempted while empty.

Behaviour:
Reset (asynchronous, rst=1):
- Write and read pointers = 0; fcount = 0; dout = 0.
- fempty = 1; ffull = 0; foverflow = 0; funderflow = 0.
- fthreshold = (thresh_level == 0).
- Memory contents are not reset.

Pointers and flags:
- Pointers are AW+1 bits; the extra MSB is the wrap bit.
- Empty when the pointers are fully equal.
- Full when the address bits are equal and the wrap bits differ.
- ffull, fempty and fcount are registered and correct in the cycle after the accepted operation.

Accept rules:
- Write is accepted when wr && !ffull. Accepted write stores din at mem[wptr[AW-1:0]], then wptr increments.
- Read is accepted when rd && !fempty. Accepted read increments rptr.

Occupancy:
- Write only: fcount +1.
- Read only: fcount -1.
- Both accepted in the same cycle: fcount unchanged, both pointers advance.
- wr&&rd while full: read accepted, write rejected. fcount goes DEPTH -> DEPTH-1 and foverflow is set.
- wr&&rd while empty: write accepted, read rejected. fcount goes 0 -> 1 and funderflow is set.
- Pointer wrap: address bits roll from DEPTH-1 to 0 and the wrap bit toggles. No other effect.

Read data:
- FWFT=0: on an accepted read, dout is registered with mem[rptr] and is valid the cycle after rd. Otherwise dout holds its last value.
- FWFT=1: dout = mem[rptr[AW-1:0]] continuously while !fempty; the head word is visible the cycle after it is written into an empty FIFO. rd pops the head. dout is don't-care while fempty=1.

Threshold:
- fthreshold is combinational: registered fcount compared with thresh_level, unsigned.
- thresh_level > DEPTH: fthreshold is never asserted.

Error flags:
- foverflow is set on the clock edge where wr=1 and ffull=1.
- funderflow is set on the clock edge where rd=1 and fempty=1.
- Both hold until flag_clr=1 or reset.
- If flag_clr and a new error event occur in the same cycle, the set wins (flag = 1).
- Rejected operations never modify pointers, memory or dout.

Reset mid-operation:
- Asserting rst asynchronously returns every output to its reset value.
- The first operation after deassertion writes address 0.

Test Plan:
1. Reset, then 16 writes of 0x00..0x0F (DW=8, DEPTH=16) -> fcount increments 1..16, ffull=1 after the 16th, fempty=0. Read 16 -> dout 0x00..0x0F in order, one cycle after each rd (FWFT=0); fempty=1 at the end.
2. Full FIFO, wr=1 with din=0xAA -> foverflow=1 and stays set. Drain 16 -> 0xAA never appears. flag_clr pulse -> foverflow=0.
3. Empty FIFO, rd=1 -> funderflow=1, fcount=0, dout unchanged. Same-cycle wr=1 with 0x55 and rd=1 on empty -> fcount=1, next read returns 0x55.
4. thresh_level=5: fthreshold=0 at fcount=4 and 1 at fcount=5. Change to 3 at fcount=5 -> stays 1. Set to 17 -> 0 even when full.
5. Write 10 / read 10 repeatedly for 40 words, plus simultaneous wr&rd at fcount=7 for 20 cycles -> fcount stays 7, data in order across pointer wrap.
6. FWFT=1: write 0x3C into empty -> dout=0x3C the next cycle with no rd. rd -> fempty=1. rst asserted mid-stream at fcount=9 -> fcount=0, fempty=1, flags 0 immediately.
